// File: rtl/sprite_addr_gen.sv
// Sprite ROM address generator: tracks board square/offset from the scan position,
// holds the 8x8 board state and aligns per-pixel flags with the ROM read data.
module sprite_addr_gen #(
  parameter int BOARD_X0 = 140,
  parameter int BOARD_Y0 = 60,
  parameter int SQ_PIX   = 45,
  parameter int EMPTY    = 12
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        wr_en,
  input  logic [5:0]  wr_square,
  input  logic [3:0]  wr_piece,
  input  logic [5:0]  cursor_square,
  output logic [14:0] read_address,
  output logic        in_board_d,
  output logic        dark_sq_d,
  output logic        cursor_hit_d
);

  localparam logic [9:0]  X0         = 10'(BOARD_X0);
  localparam logic [9:0]  Y0         = 10'(BOARD_Y0);
  localparam logic [9:0]  X_LAST     = 10'(BOARD_X0 + 8*SQ_PIX - 1);
  localparam logic [9:0]  Y_LAST     = 10'(BOARD_Y0 + 8*SQ_PIX - 1);
  localparam logic [5:0]  OFF_MAX    = 6'(SQ_PIX - 1);
  localparam logic [14:0] EMPTY_BASE = 15'(EMPTY*SQ_PIX*SQ_PIX);

  function automatic logic [14:0] piece_base(input logic [3:0] code);
    logic [3:0] c;
    c = (code > 4'(EMPTY)) ? 4'(EMPTY) : code;
    return 15'(c) * 15'(SQ_PIX*SQ_PIX);
  endfunction

  function automatic logic [3:0] start_piece(input logic [5:0] idx);
    logic [3:0] p;
    case (idx[5:3])
      3'd0: case (idx[2:0])
              3'd0, 3'd7: p = 4'd0;
              3'd1, 3'd6: p = 4'd1;
              3'd2, 3'd5: p = 4'd2;
              3'd3:       p = 4'd3;
              default:    p = 4'd4;
            endcase
      3'd1: p = 4'd5;
      3'd6: p = 4'd6;
      3'd7: case (idx[2:0])
              3'd0, 3'd7: p = 4'd7;
              3'd1, 3'd6: p = 4'd8;
              3'd2, 3'd5: p = 4'd9;
              3'd3:       p = 4'd10;
              default:    p = 4'd11;
            endcase
      default: p = 4'(EMPTY);
    endcase
    return p;
  endfunction

  logic [3:0]  board [64];
  logic [5:0]  col_off, row_off;
  logic [2:0]  sq_col, sq_row;
  logic        in_b, synced;
  logic        in_b2, dark2, hit2;
  logic        x_start, y_start, x_tail, y_tail, in_rng;
  logic [5:0]  sq_idx;
  logic [14:0] pix_off;

  always_comb begin
    x_start = (DrawX == X0);
    y_start = (DrawY == Y0);
    x_tail  = (DrawX > X0) && (DrawX <= X_LAST);
    y_tail  = (DrawY > Y0) && (DrawY <= Y_LAST);
    in_rng  = (DrawX >= X0) && (DrawX <= X_LAST) && (DrawY >= Y0) && (DrawY <= Y_LAST);
    sq_idx  = {sq_row, sq_col};
    pix_off = 15'(row_off) * 15'(SQ_PIX) + 15'(col_off);
  end

  // Stage 1: square/offset counters; row counters only step at the line's first board column
  always_ff @(posedge Clk) begin
    if (Reset) begin
      col_off <= '0;
      sq_col  <= '0;
      row_off <= '0;
      sq_row  <= '0;
      in_b    <= 1'b0;
      synced  <= 1'b0;
    end else begin
      if (x_start) begin
        col_off <= '0;
        sq_col  <= '0;
        if (y_start) begin
          row_off <= '0;
          sq_row  <= '0;
        end else if (y_tail) begin
          if (row_off == OFF_MAX) begin
            row_off <= '0;
            sq_row  <= sq_row + 3'd1;
          end else begin
            row_off <= row_off + 6'd1;
          end
        end
      end else if (x_tail) begin
        if (col_off == OFF_MAX) begin
          col_off <= '0;
          sq_col  <= sq_col + 3'd1;
        end else begin
          col_off <= col_off + 6'd1;
        end
      end
      if (x_start && y_start) synced <= 1'b1;
      in_b <= in_rng && (synced || (x_start && y_start));
    end
  end

  // Board state; a stage-2 read in the write cycle sees the old piece
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 64; i++) board[i] <= start_piece(6'(i));
    end else if (wr_en) begin
      board[wr_square] <= wr_piece;
    end
  end

  // Stage 2 address, stage 3 flag alignment with ROM data
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address <= '0;
      in_b2        <= 1'b0;
      dark2        <= 1'b0;
      hit2         <= 1'b0;
      in_board_d   <= 1'b0;
      dark_sq_d    <= 1'b0;
      cursor_hit_d <= 1'b0;
    end else begin
      read_address <= in_b ? piece_base(board[sq_idx]) + pix_off : EMPTY_BASE;
      in_b2        <= in_b;
      dark2        <= in_b && (sq_row[0] ^ sq_col[0]);
      hit2         <= in_b && (sq_idx == cursor_square);
      in_board_d   <= in_b2;
      dark_sq_d    <= dark2;
      cursor_hit_d <= hit2;
    end
  end

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Directed bench for sprite_addr_gen: watched pixels per frame with hand-computed
// addresses and flags, plus write-collision and mid-frame reset sequences.
module tb_sprite_addr_gen;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        wr_en;
  logic [5:0]  wr_square;
  logic [3:0]  wr_piece;
  logic [5:0]  cursor_square;
  logic [14:0] read_address;
  logic        in_board_d, dark_sq_d, cursor_hit_d;

  sprite_addr_gen dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .wr_en(wr_en), .wr_square(wr_square), .wr_piece(wr_piece),
    .cursor_square(cursor_square), .read_address(read_address),
    .in_board_d(in_board_d), .dark_sq_d(dark_sq_d), .cursor_hit_d(cursor_hit_d)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int scen;
    int x;
    int y;
    int addr;
    int inb;
    int dark;
    int hit;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cur_scen = 0;
  int   hx[3] = '{-1, -1, -1};
  int   hy[3] = '{-1, -1, -1};

  task automatic add(input int s, input int x, input int y, input int a,
                     input int ib, input int dk, input int ht);
    vec_t v;
    v.scen = s; v.x = x; v.y = y; v.addr = a; v.inb = ib; v.dark = dk; v.hit = ht;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (scenario %0d)", name, act, exp, cur_scen);
    end
  endtask

  // Pixel sampled at edge s: address visible after edge s+1, flags after edge s+2
  task automatic check_hist();
    foreach (vecs[i]) begin
      if (vecs[i].scen == cur_scen) begin
        if (hx[1] == vecs[i].x && hy[1] == vecs[i].y)
          chk($sformatf("addr(%0d,%0d)", vecs[i].x, vecs[i].y), int'(read_address), vecs[i].addr);
        if (hx[2] == vecs[i].x && hy[2] == vecs[i].y) begin
          chk($sformatf("in_board(%0d,%0d)", vecs[i].x, vecs[i].y), int'(in_board_d), vecs[i].inb);
          chk($sformatf("dark(%0d,%0d)", vecs[i].x, vecs[i].y), int'(dark_sq_d), vecs[i].dark);
          chk($sformatf("hit(%0d,%0d)", vecs[i].x, vecs[i].y), int'(cursor_hit_d), vecs[i].hit);
        end
      end
    end
  endtask

  task automatic step(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge Clk);
    #1;
    hx[2] = hx[1]; hy[2] = hy[1];
    hx[1] = hx[0]; hy[1] = hy[0];
    hx[0] = x;     hy[0] = y;
    check_hist();
  endtask

  function automatic bit row_watched(input int y);
    foreach (vecs[i]) if (vecs[i].scen == cur_scen && vecs[i].y == y) return 1'b1;
    return 1'b0;
  endfunction

  // Watched rows are scanned contiguously; other rows only touch the line-start column
  task automatic scan_frame(input int wx, input int wy, input int wsq, input int wpc);
    for (int y = 0; y < 525; y++) begin
      if (row_watched(y)) begin
        for (int x = 130; x <= 510; x++) begin
          if (x == wx && y == wy) begin
            wr_en = 1'b1; wr_square = 6'(wsq); wr_piece = 4'(wpc);
          end
          step(x, y);
          wr_en = 1'b0;
        end
      end else begin
        step(140, y);
        step(600, y);
      end
    end
  endtask

  initial begin
    // scenario 1: start position, cursor on h1
    add(1, 140,  60,     0, 1, 0, 0);
    add(1, 184,  60,    44, 1, 0, 0);
    add(1, 185,  60,  2025, 1, 1, 0);
    add(1, 323,  62,  8193, 1, 0, 0);
    add(1, 139,  62, 24300, 0, 0, 0);
    add(1, 140, 105, 10125, 1, 1, 0);
    add(1, 499, 419, 16199, 1, 0, 1);
    add(1, 500, 419, 24300, 0, 0, 0);
    // scenario 2: white queen written to square 36, cursor on it
    add(2, 320, 240, 20250, 1, 0, 1);
    add(2, 364, 240, 20294, 1, 0, 1);
    add(2, 319, 240, 24344, 1, 1, 0);
    add(2, 365, 240, 24300, 1, 1, 0);
    add(2, 499, 419, 16199, 1, 0, 0);
    // scenario 4: square 0 overwritten with code 15 as its pixel reaches stage 2
    add(4, 140,  60,     0, 1, 0, 0);
    add(4, 141,  60, 24301, 1, 0, 0);
    // scenario 5: following frame sees the empty tile
    add(5, 140,  60, 24300, 1, 0, 0);
    add(5, 184,  60, 24344, 1, 0, 0);

    Reset = 1'b1; wr_en = 1'b0; wr_square = '0; wr_piece = '0;
    cursor_square = 6'd63; DrawX = '0; DrawY = '0;
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    chk("reset read_address", int'(read_address), 0);
    chk("reset in_board_d", int'(in_board_d), 0);
    chk("reset dark_sq_d", int'(dark_sq_d), 0);
    chk("reset cursor_hit_d", int'(cursor_hit_d), 0);

    cur_scen = 1;
    scan_frame(-1, -1, 0, 0);

    wr_en = 1'b1; wr_square = 6'd36; wr_piece = 4'd10;
    step(600, 0);
    wr_en = 1'b0;
    cursor_square = 6'd36;
    cur_scen = 2;
    scan_frame(-1, -1, 0, 0);

    cursor_square = 6'd63;
    cur_scen = 4;
    scan_frame(141, 60, 0, 15);
    cur_scen = 5;
    scan_frame(-1, -1, 0, 0);

    // mid-frame reset at (300,200); nothing may look on-board until the next frame start
    cur_scen = 7;
    for (int y = 0; y < 200; y++) begin
      step(140, y);
      step(600, y);
    end
    for (int x = 130; x < 300; x++) step(x, 200);
    Reset = 1'b1;
    step(300, 200);
    Reset = 1'b0;
    chk("midreset read_address", int'(read_address), 0);
    chk("midreset in_board_d", int'(in_board_d), 0);
    for (int y = 200; y < 525; y++) begin
      for (int x = (y == 200) ? 301 : 130; x <= 510; x += ((y == 240 || y == 200) ? 1 : 380)) begin
        step(x, y);
        chk("unsynced read_address", int'(read_address), 24300);
        chk("unsynced in_board_d", int'(in_board_d), 0);
        chk("unsynced dark_sq_d", int'(dark_sq_d), 0);
        chk("unsynced cursor_hit_d", int'(cursor_hit_d), 0);
      end
    end

    hx = '{-1, -1, -1};
    hy = '{-1, -1, -1};
    cur_scen = 1;
    scan_frame(-1, -1, 0, 0);
    step(600, 0);
    step(600, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
